// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_arbiter_pkg
//   Shared definitions for the MINISYS data-bus arbiter: FSM state encoding,
//   bus-owner encoding and the default address/data widths.
//   Optional feature macro used by the arbiter files: ARB_ROUND_ROBIN_EN.
package mem_bus_arbiter_pkg;

  localparam int ADDR_W_DEF = 14;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_e;

  localparam logic OWNER_CPU = 1'b0;
  localparam logic OWNER_LDR = 1'b1;

endpackage

// File: rtl/mem_bus_arbiter_arb_pick2.sv
// arb_pick2
//   Combinational 2-way grant selection between the CPU (req0) and the
//   loader (req1).
//   Build option: ARB_ROUND_ROBIN_EN defined -> a tie goes to the master that
//   was not served last; undefined -> the loader wins every tie.
// Ports:
//   req0        in  CPU request
//   req1        in  loader request
//   last_owner  in  owner of the last access (OWNER_CPU / OWNER_LDR)
//   grant_valid out at least one request is present
//   grant_owner out selected master (meaningful only when grant_valid)
module arb_pick2
  import mem_bus_arbiter_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_owner,
  output logic grant_valid,
  output logic grant_owner
);

`ifndef ARB_ROUND_ROBIN_EN
  // Fixed priority never looks at history.
  logic unused_last_owner;
  assign unused_last_owner = last_owner;
`endif

  always_comb begin
    grant_valid = req0 | req1;
    grant_owner = OWNER_CPU;
    if (req0 && req1) begin
`ifdef ARB_ROUND_ROBIN_EN
      grant_owner = ~last_owner;
`else
      grant_owner = OWNER_LDR;
`endif
    end else if (req1) begin
      grant_owner = OWNER_LDR;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Shares the single-port data RAM between the CPU data port and the UART
//   program loader. Requests are sampled only in IDLE; a granted access
//   drives the RAM for one cycle (ACCESS) and completes with a one-cycle ack
//   in RESP, giving one access per three cycles.
//   Build option: ARB_ROUND_ROBIN_EN (see arb_pick2) selects tie policy.
//
// Handshake: a master raises req with stable we/addr/wdata and holds them
//   until its ack pulse; operands are latched at grant, later changes are
//   ignored. In the cycle after ack the master drops req or presents a new
//   access; RESP never re-arbitrates, so no access is issued twice.
//
// Ports:
//   iCpuClock / iCpuReset          clock, synchronous active-high reset
//   iCpuReq/We/Addr/Wdata          CPU request port
//   oCpuAck/oCpuRdata/oCpuStall    CPU completion, read data, fetch stall
//   iLdrReq/We/Addr/Wdata          loader request port
//   oLdrAck/oLdrRdata              loader completion, read data
//   oMemEn/We/Addr/Wdata           RAM control (addr/wdata registered)
//   iMemRdata                      RAM read data, one cycle after oMemEn
//   oBusOwner                      owner of current/last access (1 = loader)
//   oDbgState                      FSM state for observation
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              iCpuClock,
  input  logic              iCpuReset,
  input  logic              iCpuReq,
  input  logic              iCpuWe,
  input  logic [ADDR_W-1:0] iCpuAddr,
  input  logic [DATA_W-1:0] iCpuWdata,
  output logic              oCpuAck,
  output logic [DATA_W-1:0] oCpuRdata,
  output logic              oCpuStall,
  input  logic              iLdrReq,
  input  logic              iLdrWe,
  input  logic [ADDR_W-1:0] iLdrAddr,
  input  logic [DATA_W-1:0] iLdrWdata,
  output logic              oLdrAck,
  output logic [DATA_W-1:0] oLdrRdata,
  output logic              oMemEn,
  output logic              oMemWe,
  output logic [ADDR_W-1:0] oMemAddr,
  output logic [DATA_W-1:0] oMemWdata,
  input  logic [DATA_W-1:0] iMemRdata,
  output logic              oBusOwner,
  output logic [1:0]        oDbgState
);

  arb_state_e        state_q, state_d;
  logic              owner_q, owner_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  logic grant_valid;
  logic grant_owner;

  arb_pick2 u_pick (
    .req0        (iCpuReq),
    .req1        (iLdrReq),
    .last_owner  (owner_q),
    .grant_valid (grant_valid),
    .grant_owner (grant_owner)
  );

  // State register (also holds the latched access operands).
  always_ff @(posedge iCpuClock) begin
    if (iCpuReset) begin
      state_q     <= IDLE;
      owner_q     <= OWNER_LDR;  // first round-robin tie goes to the CPU
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // Next-state logic; operands are captured only on a grant in IDLE.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          state_d = ACCESS;
          owner_d = grant_owner;
          if (grant_owner == OWNER_LDR) begin
            mem_we_d    = iLdrWe;
            mem_addr_d  = iLdrAddr;
            mem_wdata_d = iLdrWdata;
          end else begin
            mem_we_d    = iCpuWe;
            mem_addr_d  = iCpuAddr;
            mem_wdata_d = iCpuWdata;
          end
        end
      end
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs. Strobes are gated by reset so an abandoned access neither
  // writes the RAM nor acks.
  always_comb begin
    oMemEn    = 1'b0;
    oMemWe    = 1'b0;
    oCpuAck   = 1'b0;
    oLdrAck   = 1'b0;
    oCpuRdata = '0;
    oLdrRdata = '0;
    if (!iCpuReset) begin
      if (state_q == ACCESS) begin
        oMemEn = 1'b1;
        oMemWe = mem_we_q;
      end
      if (state_q == RESP) begin
        oCpuAck = (owner_q == OWNER_CPU);
        oLdrAck = (owner_q == OWNER_LDR);
        if (!mem_we_q) begin
          if (owner_q == OWNER_CPU) oCpuRdata = iMemRdata;
          else                      oLdrRdata = iMemRdata;
        end
      end
    end
  end

  assign oCpuStall = iCpuReq & ~oCpuAck;
  assign oMemAddr  = mem_addr_q;
  assign oMemWdata = mem_wdata_q;
  assign oBusOwner = owner_q;
  assign oDbgState = state_q;

endmodule
